// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU program sequencer: FSM states, instruction
// field layout and ALU op encodings.
package alu_seq_pkg;

    localparam int INSTR_W = 8;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 6;
    localparam int RK_MSB = 5;
    localparam int RK_LSB = 4;
    localparam int RI_MSB = 3;
    localparam int RI_LSB = 2;
    localparam int RJ_MSB = 1;
    localparam int RJ_LSB = 0;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] rk;
        logic [1:0] ri;
        logic [1:0] rj;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        instr_t d;
        d.op = raw[OP_MSB:OP_LSB];
        d.rk = raw[RK_MSB:RK_LSB];
        d.ri = raw[RI_MSB:RI_LSB];
        d.rj = raw[RJ_MSB:RJ_LSB];
        return d;
    endfunction

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Instruction store for the ALU sequencer: one write port and one
// registered read port. Contents are deliberately not reset.
module alu_seq_prog_mem
    import alu_seq_pkg::*;
#(
    parameter int PROG_DEPTH = 8,
    parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Program sequencer for the 4x1-bit register ALU: runs the instruction store
// from address 0, one instruction per two clocks. Define SINGLE_STEP_EN to add
// the step port, which gates each FETCH->EXEC transition.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PROG_DEPTH = 8,
    parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic [ADDR_W:0]    len,
`ifdef SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic [1:0]         sel_Ri,
    output logic [1:0]         sel_Rj,
    output logic [1:0]         sel_Rk,
    output logic [1:0]         sel_op,
    output logic               exec_en,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  pc
);

    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(PROG_DEPTH);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   pc_q, pc_next;
    logic [ADDR_W:0]     len_q, len_next;
    logic [INSTR_W-1:0]  rd_data;
    instr_t              cur;
    logic                mem_we, mem_re, last_instr, fetch_go;

    logic [1:0]          sel_Ri_d, sel_Rj_d, sel_Rk_d, sel_op_d;
    logic                exec_en_d, busy_d, done_d;
    logic [ADDR_W-1:0]   pc_d;

    // The store is only writable while idle so a running program cannot change.
    assign mem_we     = (state == IDLE) && prog_we;
    assign mem_re     = (state == FETCH);
    assign last_instr = ({1'b0, pc_q} == (len_q - (ADDR_W+1)'(1)));
    assign cur        = decode_instr(rd_data);

`ifdef SINGLE_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    alu_seq_prog_mem #(
        .PROG_DEPTH (PROG_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (mem_re),
        .raddr (pc_q),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            sel_Ri  <= '0;
            sel_Rj  <= '0;
            sel_Rk  <= '0;
            sel_op  <= '0;
            exec_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pc      <= '0;
        end else begin
            state   <= state_next;
            pc_q    <= pc_next;
            len_q   <= len_next;
            sel_Ri  <= sel_Ri_d;
            sel_Rj  <= sel_Rj_d;
            sel_Rk  <= sel_Rk_d;
            sel_op  <= sel_op_d;
            exec_en <= exec_en_d;
            busy    <= busy_d;
            done    <= done_d;
            pc      <= pc_d;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        len_next   = len_q;
        case (state)
            IDLE: begin
                if (start) begin
                    len_next   = (len > DEPTH_LEN) ? DEPTH_LEN : len;
                    pc_next    = '0;
                    state_next = (len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (fetch_go) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (last_instr) begin
                    state_next = DONE;
                end else begin
                    pc_next    = pc_q + 1'b1;
                    state_next = FETCH;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so they trail it by one edge.
    always_comb begin
        sel_Ri_d  = sel_Ri;
        sel_Rj_d  = sel_Rj;
        sel_Rk_d  = sel_Rk;
        sel_op_d  = sel_op;
        exec_en_d = (state == EXEC);
        busy_d    = (state != IDLE);
        done_d    = (state == DONE);
        pc_d      = pc_q;
        if (state == EXEC) begin
            sel_Ri_d = cur.ri;
            sel_Rj_d = cur.rj;
            sel_Rk_d = cur.rk;
            sel_op_d = cur.op;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer; define SINGLE_STEP_EN to also exercise
// the single-step gate.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       prog_we = 1'b0;
    logic [2:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic       start = 1'b0;
    logic [3:0] len = '0;
`ifdef SINGLE_STEP_EN
    logic       step = 1'b1;
`endif
    logic [1:0] sel_Ri, sel_Rj, sel_Rk, sel_op;
    logic       exec_en, busy, done;
    logic [2:0] pc;

    alu_sequencer #(.PROG_DEPTH(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .len       (len),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .sel_Ri    (sel_Ri),
        .sel_Rj    (sel_Rj),
        .sel_Rk    (sel_Rk),
        .sel_op    (sel_op),
        .exec_en   (exec_en),
        .busy      (busy),
        .done      (done),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int op, rk, ri, rj, pcv, edge_no;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         edge_cnt = 0;
    int         exec_seen = 0;
    logic [7:0] shadow [8];
    exp_t       mon_e;
    bit         mon_ok;

    always @(posedge clk) edge_cnt++;

    // Monitor: every exec_en or done cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (exec_en) exec_seen++;
            if (exec_en || done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_output edge=%0d exec_en=%0b done=%0b pc=%0d, required no output",
                             edge_cnt, exec_en, done, pc);
                end else begin
                    mon_e  = sb.pop_front();
                    mon_ok = (done == mon_e.is_done) && (exec_en == !mon_e.is_done) &&
                             (edge_cnt == mon_e.edge_no);
                    if (!mon_e.is_done)
                        mon_ok = mon_ok && (int'(sel_op) == mon_e.op) && (int'(sel_Rk) == mon_e.rk) &&
                                 (int'(sel_Ri) == mon_e.ri) && (int'(sel_Rj) == mon_e.rj) &&
                                 (int'(pc) == mon_e.pcv);
                    if (!mon_ok) begin
                        errors++;
                        $display("[TB] FAIL scoreboard got edge=%0d exec=%0b done=%0b op/rk/ri/rj=%0d/%0d/%0d/%0d pc=%0d, required edge=%0d done=%0b op/rk/ri/rj=%0d/%0d/%0d/%0d pc=%0d",
                                 edge_cnt, exec_en, done, sel_op, sel_Rk, sel_Ri, sel_Rj, pc,
                                 mon_e.edge_no, mon_e.is_done, mon_e.op, mon_e.rk, mon_e.ri, mon_e.rj, mon_e.pcv);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void pushExp(bit d, int op, int rk, int ri, int rj, int pcv, int edge_no);
        exp_t e;
        e.is_done = d; e.op = op; e.rk = rk; e.ri = ri; e.rj = rj; e.pcv = pcv; e.edge_no = edge_no;
        sb.push_back(e);
    endfunction

    function automatic void pushInstr(int pcv, logic [7:0] b, int edge_no);
        pushExp(1'b0, int'(b[7:6]), int'(b[5:4]), int'(b[3:2]), int'(b[1:0]), pcv, edge_no);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic writeInstr(input int addr, input logic [7:0] data);
        prog_we = 1'b1; prog_addr = 3'(addr); prog_data = data;
        shadow[addr] = data;
        tick();
        prog_we = 1'b0;
    endtask

    // Issues a start; pushes the first 'keep' execs (plus done if all are kept).
    task automatic applyStimulus(input int run_len, input int keep, output int e0);
        int eff;
        eff = (run_len > 8) ? 8 : run_len;
        start = 1'b1; len = 4'(run_len);
        e0 = edge_cnt + 1;
        for (int n = 0; n < eff && n < keep; n++) pushInstr(n, shadow[n], e0 + 2*n + 2);
        if (keep >= eff) pushExp(1'b1, 0, 0, 0, 0, 0, e0 + 2*eff + 1);
        tick();
        start = 1'b0;
    endtask

    task automatic drainCount(input int budget, output int busy_cycles);
        bit finished = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < budget && !finished; i++) begin
            tick();
            if (busy) busy_cycles++;
            if (sb.size() == 0 && !busy) finished = 1'b1;
        end
        if (!finished) begin
            checks++; errors++;
            $display("[TB] FAIL drain_timeout got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        int  e0, bc, ex0;
        bit  found;
        logic [7:0] prog8 [8];
        prog8 = '{8'h1B, 8'h64, 8'hE1, 8'h39, 8'hC6, 8'h72, 8'hAD, 8'h5F};

        repeat (3) tick();
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_exec_en", int'(exec_en), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_pc", int'(pc), 0);
        checkOutput("rst_sel", int'({sel_op, sel_Rk, sel_Ri, sel_Rj}), 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) writeInstr(i, prog8[i]);
        applyStimulus(3, 0, e0);
        pushExp(1'b0, 0, 1, 2, 3, 0, e0 + 2);
        pushExp(1'b0, 1, 2, 1, 0, 1, e0 + 4);
        pushExp(1'b0, 3, 2, 0, 1, 2, e0 + 6);
        pushExp(1'b1, 0, 0, 0, 0, 0, e0 + 7);
        drainCount(40, bc);
        checkOutput("len3_busy_cycles", bc, 7);
        checkOutput("len3_sel_hold", int'({sel_op, sel_Rk, sel_Ri, sel_Rj}), 8'hE1);

        ex0 = exec_seen;
        applyStimulus(0, 0, e0);
        drainCount(20, bc);
        checkOutput("len0_busy_cycles", bc, 1);
        checkOutput("len0_execs", exec_seen - ex0, 0);

        for (int i = 3; i < 8; i++) writeInstr(i, prog8[i]);
        ex0 = exec_seen;
        applyStimulus(8, 8, e0);
        drainCount(60, bc);
        checkOutput("len8_busy_cycles", bc, 17);
        checkOutput("len8_execs", exec_seen - ex0, 8);

        ex0 = exec_seen;
        applyStimulus(15, 15, e0);
        drainCount(60, bc);
        checkOutput("len15_busy_cycles", bc, 17);
        checkOutput("len15_execs", exec_seen - ex0, 8);

        // Stray start and store write while running must both be ignored.
        ex0 = exec_seen;
        applyStimulus(3, 3, e0);
        tick(); tick();
        start = 1'b1; len = 4'd8; prog_we = 1'b1; prog_addr = 3'd1; prog_data = 8'h00;
        tick();
        start = 1'b0; prog_we = 1'b0;
        drainCount(60, bc);
        checkOutput("busy_ignore_execs", exec_seen - ex0, 3);
        applyStimulus(2, 2, e0);
        drainCount(40, bc);
        checkOutput("readback_busy_cycles", bc, 5);

        // Write coincident with start is visible to instruction 0.
        prog_we = 1'b1; prog_addr = 3'd0; prog_data = 8'h96;
        start = 1'b1; len = 4'd1;
        shadow[0] = 8'h96;
        e0 = edge_cnt + 1;
        pushInstr(0, 8'h96, e0 + 2);
        pushExp(1'b1, 0, 0, 0, 0, 0, e0 + 3);
        tick();
        start = 1'b0; prog_we = 1'b0;
        drainCount(20, bc);
        checkOutput("coincident_busy_cycles", bc, 3);

        // Reset mid-run once instruction 3 has executed.
        applyStimulus(8, 4, e0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk); #2;
            if (exec_en && pc == 3'd3) found = 1'b1;
        end
        checkOutput("midrun_reached_pc3", int'(found), 1);
        reset = 1'b0;
        tick();
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_exec_en", int'(exec_en), 0);
        checkOutput("midrst_pc", int'(pc), 0);
        checkOutput("midrst_sel", int'({sel_op, sel_Rk, sel_Ri, sel_Rj}), 0);
        checkOutput("midrst_pending", sb.size(), 0);
        reset = 1'b1;
        tick();
        ex0 = exec_seen;
        applyStimulus(8, 8, e0);
        drainCount(60, bc);
        checkOutput("postrst_execs", exec_seen - ex0, 8);

`ifdef SINGLE_STEP_EN
        step = 1'b0;
        ex0 = exec_seen;
        applyStimulus(2, 0, e0);
        repeat (5) tick();
        checkOutput("step_hold_execs", exec_seen - ex0, 0);
        checkOutput("step_hold_busy", int'(busy), 1);
        checkOutput("step_hold_pc", int'(pc), 0);
        pushInstr(0, shadow[0], edge_cnt + 2);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (4) tick();
        checkOutput("step_one_exec", exec_seen - ex0, 1);
        checkOutput("step_one_no_done", int'(done), 0);
        pushInstr(1, shadow[1], edge_cnt + 2);
        pushExp(1'b1, 0, 0, 0, 0, 0, edge_cnt + 3);
        step = 1'b1;
        tick();
        step = 1'b0;
        drainCount(20, bc);
        checkOutput("step_two_execs", exec_seen - ex0, 2);
        step = 1'b1;
`endif

        repeat (2) tick();
        checkOutput("sb_empty_end", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
